// File: rtl/present_pkg.sv
// Shared types, widths and the PRESENT bit-permutation index for the encryption core.
package present_pkg;

   localparam int BLK_W          = 64;
   localparam int KEY_W          = 80;
   localparam int ROUNDS_DEFAULT = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } fsm_t;

   // Forward pLayer destination of bit i; the MSB is the fixed point.
   function automatic int p_idx(input int i);
      return (i == BLK_W - 1) ? i : (i * 16) % (BLK_W - 1);
   endfunction

endpackage

// File: rtl/present_encrypt_if.sv
// Block-level handshake and data bus of the PRESENT-80 encryption core.
interface present_encrypt_if;
   import present_pkg::*;

   logic             chip_enable;
   logic             load;
   logic [BLK_W-1:0] idat;
   logic [KEY_W-1:0] key;
   logic [BLK_W-1:0] odat;
   logic             done;
   logic             busy;

   modport master (
      output chip_enable, load, idat, key,
      input  odat, done, busy
   );

   modport slave (
      input  chip_enable, load, idat, key,
      output odat, done, busy
   );

endinterface

// File: rtl/pbox.sv
// PRESENT forward bit permutation (pLayer); pure wiring.
module pbox
   import present_pkg::*;
(
   input  logic [BLK_W-1:0] i_dat,
   output logic [BLK_W-1:0] o_dat
);

   for (genvar i = 0; i < BLK_W; i++) begin : g_bit
      assign o_dat[p_idx(i)] = i_dat[i];
   end

endmodule

// File: rtl/sbox.sv
// PRESENT 4-bit substitution box.
module sbox (
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   always_comb begin
      o_nib = 4'h0;
      case (i_nib)
         4'h0: o_nib = 4'hC;
         4'h1: o_nib = 4'h5;
         4'h2: o_nib = 4'h6;
         4'h3: o_nib = 4'hB;
         4'h4: o_nib = 4'h9;
         4'h5: o_nib = 4'h0;
         4'h6: o_nib = 4'hA;
         4'h7: o_nib = 4'hD;
         4'h8: o_nib = 4'h3;
         4'h9: o_nib = 4'hE;
         4'hA: o_nib = 4'hF;
         4'hB: o_nib = 4'h8;
         4'hC: o_nib = 4'h4;
         4'hD: o_nib = 4'h7;
         4'hE: o_nib = 4'h1;
         4'hF: o_nib = 4'h2;
         default: o_nib = 4'h0;
      endcase
   end

endmodule

// File: rtl/present_encrypt.sv
// Iterative PRESENT-80 encryption: one round per clock, final whitening in FINISH.
module present_encrypt
   import present_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEFAULT
)(
   input  logic             clk,
   input  logic             rst,
   present_encrypt_if.slave bus
);

   localparam logic [4:0] LAST_RND = 5'(ROUNDS);

   fsm_t             r_fsm;
   logic [BLK_W-1:0] r_state;
   logic [KEY_W-1:0] r_kreg;
   logic [4:0]       r_round;
   logic [BLK_W-1:0] r_odat;
   logic             r_done;

   fsm_t             w_fsm_nxt;
   logic [BLK_W-1:0] w_state_nxt;
   logic [KEY_W-1:0] w_kreg_nxt;
   logic [4:0]       w_round_nxt;
   logic [BLK_W-1:0] w_odat_nxt;
   logic             w_done_nxt;

   logic [BLK_W-1:0] w_addkey;
   logic [BLK_W-1:0] w_sub;
   logic [BLK_W-1:0] w_state_rnd;
   logic [KEY_W-1:0] w_krot;
   logic [3:0]       w_knib;
   logic [KEY_W-1:0] w_kreg_rnd;

   // Round datapath: addRoundKey -> sLayer -> pLayer.
   assign w_addkey = r_state ^ r_kreg[KEY_W-1:KEY_W-BLK_W];

   for (genvar n = 0; n < BLK_W / 4; n++) begin : g_sbox
      sbox u_sbox (
         .i_nib (w_addkey[4*n +: 4]),
         .o_nib (w_sub[4*n +: 4])
      );
   end

   pbox u_pbox (
      .i_dat (w_sub),
      .o_dat (w_state_rnd)
   );

   // Key schedule: rotate left 61, S-box the top nibble, mix in the round counter.
   assign w_krot = {r_kreg[18:0], r_kreg[79:19]};

   sbox u_sbox_key (
      .i_nib (w_krot[79:76]),
      .o_nib (w_knib)
   );

   assign w_kreg_rnd = {w_knib, w_krot[75:20], w_krot[19:15] ^ r_round, w_krot[14:0]};

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_state_nxt = r_state;
      w_kreg_nxt  = r_kreg;
      w_round_nxt = r_round;
      w_odat_nxt  = r_odat;
      w_done_nxt  = 1'b0;
      if (bus.chip_enable) begin
         case (r_fsm)
            IDLE: ;
            RUN: begin
               w_state_nxt = w_state_rnd;
               w_kreg_nxt  = w_kreg_rnd;
               w_round_nxt = r_round + 5'd1;
               if (r_round == LAST_RND) w_fsm_nxt = FINISH;
            end
            FINISH: begin
               w_odat_nxt = r_state ^ r_kreg[KEY_W-1:KEY_W-BLK_W];
               w_done_nxt = 1'b1;
               w_fsm_nxt  = IDLE;
            end
            default: w_fsm_nxt = IDLE;
         endcase
         // A load overrides any round in flight; FINISH still emits its result above.
         if (bus.load) begin
            w_state_nxt = bus.idat;
            w_kreg_nxt  = bus.key;
            w_round_nxt = 5'd1;
            w_fsm_nxt   = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm   <= IDLE;
         r_round <= 5'd0;
         r_odat  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_round <= w_round_nxt;
         r_odat  <= w_odat_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_state <= w_state_nxt;
      r_kreg  <= w_kreg_nxt;
   end

   assign bus.odat = r_odat;
   assign bus.done = r_done;
   assign bus.busy = (r_fsm != IDLE);

endmodule
